// File: rtl/stim_seq_pkg.sv
// stim_seq_pkg
// Shared types and default constants for the stimulus sequencer.
//   state_t : playback FSM states (IDLE / RUN / FIN)
//   entry_t : one table entry {value, delay} at the default widths
//   DEF_*   : default parameter values used by stim_sequencer and stim_seq_table
package stim_seq_pkg;

   localparam int DEF_NUM_CH = 2;
   localparam int DEF_DEPTH  = 8;
   localparam int DEF_DLY_W  = 16;
   localparam int DEF_TMO_W  = 20;
   localparam int EVT_CNT_W  = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   typedef struct packed {
      logic [DEF_NUM_CH-1:0] value;
      logic [DEF_DLY_W-1:0]  delay;
   } entry_t;

endpackage

// File: rtl/stim_seq_table.sv
// stim_seq_table
// DEPTH x {value, delay} register file. Synchronous write, asynchronous read.
// Contents are deliberately not reset; entries are undefined until written.
// Ports:
//   clk                 clock
//   we, wr_idx          write strobe and index
//   wr_value, wr_delay  entry data to store
//   rd_idx              read index
//   rd_value, rd_delay  entry data at rd_idx (combinational)
module stim_seq_table
   import stim_seq_pkg::*;
#(
   parameter int NUM_CH = DEF_NUM_CH,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int DLY_W  = DEF_DLY_W,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     wr_idx,
   input  logic [NUM_CH-1:0] wr_value,
   input  logic [DLY_W-1:0]  wr_delay,
   input  logic [AW-1:0]     rd_idx,
   output logic [NUM_CH-1:0] rd_value,
   output logic [DLY_W-1:0]  rd_delay
);

   logic [NUM_CH-1:0] value_q [DEPTH];
   logic [DLY_W-1:0]  delay_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         value_q[wr_idx] <= wr_value;
         delay_q[wr_idx] <= wr_delay;
      end
   end

   assign rd_value = value_q[rd_idx];
   assign rd_delay = delay_q[rd_idx];

endmodule

// File: rtl/stim_sequencer.sv
// stim_sequencer
// Plays a programmed table of (value, hold-cycles) entries onto stim_out,
// optionally looping, with a run-length watchdog that forces termination.
// Optional build macro: STIM_SEQ_TRACE_EN adds evt_pulse / evt_cnt outputs.
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   cfg_we/addr/value/delay          table write port (ignored while busy)
//   cfg_len, loop_en, tmo_limit      run configuration, captured at start
//   start, stop                      playback start / abort pulses
//   stim_out                         stimulus bus
//   busy, done, timeout, cur_idx     status
//   evt_pulse, evt_cnt               (trace build only) stim_out change events
//
// state | meaning
// IDLE  | waiting for start; table writable; stim_out holds last value
// RUN   | driving table[cur_idx] for its hold time; watchdog counting
// FIN   | one-cycle termination, done=1, then back to IDLE
module stim_sequencer
   import stim_seq_pkg::*;
#(
   parameter int NUM_CH = DEF_NUM_CH,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int DLY_W  = DEF_DLY_W,
   parameter int TMO_W  = DEF_TMO_W,
   localparam int AW    = $clog2(DEPTH),
   localparam int LW    = AW + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_we,
   input  logic [AW-1:0]     cfg_addr,
   input  logic [NUM_CH-1:0] cfg_value,
   input  logic [DLY_W-1:0]  cfg_delay,
   input  logic [LW-1:0]     cfg_len,
   input  logic [TMO_W-1:0]  tmo_limit,
   input  logic              loop_en,
   input  logic              start,
   input  logic              stop,
   output logic [NUM_CH-1:0] stim_out,
   output logic              busy,
   output logic              done,
   output logic              timeout,
   output logic [AW-1:0]     cur_idx
`ifdef STIM_SEQ_TRACE_EN
   ,
   output logic                 evt_pulse,
   output logic [EVT_CNT_W-1:0] evt_cnt
`endif
);

   state_t            state_q, state_d;
   logic [AW-1:0]     idx_q, idx_d;
   logic [AW-1:0]     last_q, last_d;
   logic              loop_q, loop_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic [DLY_W-1:0]  hold_q, hold_d;
   logic [TMO_W-1:0]  wd_q, wd_d;
   logic [NUM_CH-1:0] stim_q, stim_d;
   logic              timeout_q, timeout_d;

   logic [AW-1:0]     rd_idx;
   logic [NUM_CH-1:0] rd_value;
   logic [DLY_W-1:0]  rd_delay;
   logic [DLY_W-1:0]  hold_ld;
   logic [LW-1:0]     len_eff;
   logic              tbl_we;
   logic              wd_hit;
   logic              at_last;
   logic              start_acc;

`ifdef STIM_SEQ_TRACE_EN
   logic                 evt_pulse_q, evt_pulse_d;
   logic [EVT_CNT_W-1:0] evt_cnt_q, evt_cnt_d;
`endif

   // Table is frozen for the whole run; FIN and IDLE may write.
   assign tbl_we = cfg_we && (state_q != RUN);

   stim_seq_table #(
      .NUM_CH (NUM_CH),
      .DEPTH  (DEPTH),
      .DLY_W  (DLY_W)
   ) u_table (
      .clk      (clk),
      .we       (tbl_we),
      .wr_idx   (cfg_addr),
      .wr_value (cfg_value),
      .wr_delay (cfg_delay),
      .rd_idx   (rd_idx),
      .rd_value (rd_value),
      .rd_delay (rd_delay)
   );

   always_comb begin
      len_eff = cfg_len;
      if (cfg_len == '0 || cfg_len > LW'(DEPTH)) begin
         len_eff = LW'(DEPTH);
      end
   end

   // Hold counter counts down to 0 on the last cycle; a delay of 0 behaves as 1.
   assign hold_ld   = (rd_delay == '0) ? '0 : rd_delay - DLY_W'(1);
   assign wd_hit    = (tmo_q != '0) && (wd_q == tmo_q - TMO_W'(1));
   assign at_last   = (idx_q == last_q);
   assign start_acc = (state_q == IDLE) && start;

   // Read port looks at the entry that would be loaded next: entry 0 on start
   // or wrap, otherwise the successor of the current entry.
   assign rd_idx = (state_q == RUN && !at_last) ? idx_q + AW'(1) : '0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         last_q    <= '0;
         loop_q    <= 1'b0;
         tmo_q     <= '0;
         hold_q    <= '0;
         wd_q      <= '0;
         stim_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         last_q    <= last_d;
         loop_q    <= loop_d;
         tmo_q     <= tmo_d;
         hold_q    <= hold_d;
         wd_q      <= wd_d;
         stim_q    <= stim_d;
         timeout_q <= timeout_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      last_d    = last_q;
      loop_d    = loop_q;
      tmo_d     = tmo_q;
      hold_d    = hold_q;
      wd_d      = wd_q;
      stim_d    = stim_q;
      timeout_d = timeout_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = RUN;
               idx_d     = '0;
               stim_d    = rd_value;
               hold_d    = hold_ld;
               wd_d      = '0;
               timeout_d = 1'b0;
               last_d    = AW'(len_eff - LW'(1));
               loop_d    = loop_en;
               tmo_d     = tmo_limit;
            end
         end
         RUN: begin
            // Only counts while enabled, so a disabled watchdog cannot wrap.
            if (tmo_q != '0) begin
               wd_d = wd_q + TMO_W'(1);
            end
            // Priority: watchdog, then stop, then normal hold/advance.
            if (wd_hit) begin
               state_d   = FIN;
               timeout_d = 1'b1;
            end else if (stop) begin
               state_d = FIN;
            end else if (hold_q != '0) begin
               hold_d = hold_q - DLY_W'(1);
            end else if (!at_last || loop_q) begin
               idx_d  = rd_idx;
               stim_d = rd_value;
               hold_d = hold_ld;
            end else begin
               state_d = FIN;
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q == RUN);
      done = (state_q == FIN);
   end

   assign stim_out = stim_q;
   assign cur_idx  = idx_q;
   assign timeout  = timeout_q;

`ifdef STIM_SEQ_TRACE_EN
   // The start load always counts as an event, even if the value is unchanged.
   always_comb begin
      evt_pulse_d = start_acc || (stim_d != stim_q);
      evt_cnt_d   = evt_cnt_q;
      if (start_acc) begin
         evt_cnt_d = EVT_CNT_W'(1);
      end else if (evt_pulse_d && evt_cnt_q != '1) begin
         evt_cnt_d = evt_cnt_q + EVT_CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         evt_pulse_q <= 1'b0;
         evt_cnt_q   <= '0;
      end else begin
         evt_pulse_q <= evt_pulse_d;
         evt_cnt_q   <= evt_cnt_d;
      end
   end

   assign evt_pulse = evt_pulse_q;
   assign evt_cnt   = evt_cnt_q;
`endif

endmodule

// File: tb/tb_stim_sequencer.sv
module tb_stim_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cfg_we;
   logic [2:0]  cfg_addr;
   logic [1:0]  cfg_value;
   logic [15:0] cfg_delay;
   logic [3:0]  cfg_len;
   logic [19:0] tmo_limit;
   logic        loop_en;
   logic        start;
   logic        stop;
   logic [1:0]  stim_out;
   logic        busy;
   logic        done;
   logic        timeout;
   logic [2:0]  cur_idx;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   stim_sequencer #(
      .NUM_CH (2),
      .DEPTH  (8),
      .DLY_W  (16),
      .TMO_W  (20)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_we    (cfg_we),
      .cfg_addr  (cfg_addr),
      .cfg_value (cfg_value),
      .cfg_delay (cfg_delay),
      .cfg_len   (cfg_len),
      .tmo_limit (tmo_limit),
      .loop_en   (loop_en),
      .start     (start),
      .stop      (stop),
      .stim_out  (stim_out),
      .busy      (busy),
      .done      (done),
      .timeout   (timeout),
      .cur_idx   (cur_idx)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] a, input logic [1:0] v, input logic [15:0] d);
      cfg_we    = 1'b1;
      cfg_addr  = a;
      cfg_value = v;
      cfg_delay = d;
      tick();
      cfg_we = 1'b0;
   endtask

   // Returns sampled in the first RUN cycle.
   task automatic go();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      int ev;
      int ei;
      rst_n     = 1'b0;
      cfg_we    = 1'b0;
      cfg_addr  = '0;
      cfg_value = '0;
      cfg_delay = '0;
      cfg_len   = 4'd0;
      tmo_limit = '0;
      loop_en   = 1'b0;
      start     = 1'b0;
      stop      = 1'b0;
      tick();
      tick();
      chk("rst_stim", stim_out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_idx", cur_idx, 0);
      rst_n = 1'b1;
      tick();

      // Basic playback: (0,25),(1,35),(0,40),(1,10), no loop, no watchdog.
      wr(3'd0, 2'd0, 16'd25);
      wr(3'd1, 2'd1, 16'd35);
      wr(3'd2, 2'd0, 16'd40);
      wr(3'd3, 2'd1, 16'd10);
      cfg_len   = 4'd4;
      loop_en   = 1'b0;
      tmo_limit = 20'd0;
      go();
      for (int c = 1; c <= 110; c++) begin
         ev = (c <= 25) ? 0 : (c <= 60) ? 1 : (c <= 100) ? 0 : 1;
         ei = (c <= 25) ? 0 : (c <= 60) ? 1 : (c <= 100) ? 2 : 3;
         chk("basic_stim", stim_out, ev);
         chk("basic_idx", cur_idx, ei);
         chk("basic_busy", busy, 1);
         chk("basic_done_low", done, 0);
         tick();
      end
      chk("basic_done", done, 1);
      chk("basic_busy_fin", busy, 0);
      chk("basic_stim_fin", stim_out, 1);
      tick();
      chk("basic_done_once", done, 0);
      chk("basic_stim_idle", stim_out, 1);
      chk("basic_timeout", timeout, 0);

      // Zero delay + loop: (1,0),(2,3) -> 1,2,2,2 repeating.
      wr(3'd0, 2'd1, 16'd0);
      wr(3'd1, 2'd2, 16'd3);
      cfg_len = 4'd2;
      loop_en = 1'b1;
      go();
      for (int c = 1; c <= 12; c++) begin
         ev = ((c - 1) % 4 == 0) ? 1 : 2;
         ei = ((c - 1) % 4 == 0) ? 0 : 1;
         chk("loop_stim", stim_out, ev);
         chk("loop_idx", cur_idx, ei);
         tick();
      end
      chk("loop_stim13", stim_out, 1);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("stop_done", done, 1);
      chk("stop_timeout", timeout, 0);
      chk("stop_stim_frozen", stim_out, 1);
      tick();
      chk("stop_idle", done, 0);

      // Watchdog: limit 1000, looping forever otherwise.
      tmo_limit = 20'd1000;
      go();
      chk("wd_busy_first", busy, 1);
      repeat (999) tick();
      chk("wd_busy_last", busy, 1);
      chk("wd_done_low", done, 0);
      chk("wd_stim_last", stim_out, 2);
      tick();
      chk("wd_done", done, 1);
      chk("wd_timeout", timeout, 1);
      chk("wd_stim_frozen", stim_out, 2);
      tick();
      chk("wd_done_once", done, 0);
      chk("wd_timeout_sticky", timeout, 1);
      chk("wd_stim_idle", stim_out, 2);

      // Stop on the watchdog cycle: watchdog wins, one done pulse.
      tmo_limit = 20'd20;
      go();
      chk("col_timeout_clr", timeout, 0);
      repeat (19) tick();
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("col_done", done, 1);
      chk("col_timeout", timeout, 1);
      tick();
      chk("col_done_once", done, 0);
      tick();
      chk("col_done_quiet", done, 0);

      // Config lockout and start-in-RUN ignored.
      tmo_limit = 20'd0;
      go();
      chk("lock_timeout_clr", timeout, 0);
      chk("lock_stim1", stim_out, 1);
      cfg_we    = 1'b1;
      cfg_addr  = 3'd0;
      cfg_value = 2'd3;
      cfg_delay = 16'd0;
      tick();
      cfg_we = 1'b0;
      chk("lock_idx2", cur_idx, 1);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("lock_idx3", cur_idx, 1);
      chk("lock_stim3", stim_out, 2);
      tick();
      chk("lock_idx4", cur_idx, 1);
      tick();
      chk("lock_idx5", cur_idx, 0);
      chk("lock_entry0_kept", stim_out, 1);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("lock_stop_done", done, 1);
      chk("lock_stop_timeout", timeout, 0);
      tick();

      // Reset in the middle of a run: no done pulse, everything cleared.
      go();
      tick();
      tick();
      chk("rr_busy_pre", busy, 1);
      chk("rr_stim_pre", stim_out, 2);
      rst_n = 1'b0;
      for (int c = 0; c < 2; c++) begin
         tick();
         chk("rr_done", done, 0);
         chk("rr_stim", stim_out, 0);
         chk("rr_busy", busy, 0);
         chk("rr_idx", cur_idx, 0);
         chk("rr_timeout", timeout, 0);
      end
      rst_n = 1'b1;
      tick();
      chk("rr_done_after", done, 0);
      chk("rr_busy_after", busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/stim_sequencer.md
Name: stim_sequencer

Overview:
Synthesizable timed-waveform scheduler that replaces hand-written initial-block delay chains in our benches and FPGA bring-up tops. Plays a programmed table of (value, hold-cycles) entries onto a multi-bit stimulus bus, optionally looping. Includes a run-length watchdog that forces termination, equivalent to our "$time >= limit -> $finish" guard. Sits between the config/CPU side and the DUT stimulus inputs.

Parameters:
NUM_CH, 2, width of stim_out (one bit per driven signal)
DEPTH, 8, number of table entries (power of two, >=2)
DLY_W, 16, width of per-entry hold count
TMO_W, 20, width of watchdog limit/counter

Ports:
clk  in  1  single clock
rst_n  in  1  synchronous active-low reset
cfg_we  in  1  table write strobe
cfg_addr  in  $clog2(DEPTH)  table write index
cfg_value  in  NUM_CH  entry output value
cfg_delay  in  DLY_W  entry hold cycles
cfg_len  in  $clog2(DEPTH)+1  active entries, 1..DEPTH
tmo_limit  in  TMO_W  watchdog limit in cycles; 0 disables watchdog
loop_en  in  1  wrap to entry 0 after last entry
start  in  1  start-playback pulse
stop  in  1  abort-playback pulse
stim_out  out  NUM_CH  stimulus bus
busy  out  1  high while playing
done  out  1  one-cycle pulse on any termination
timeout  out  1  sticky: last run ended by watchdog
cur_idx  out  $clog2(DEPTH)  entry currently driven

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE, stim_out=0, busy=0, done=0, timeout=0, cur_idx=0, counters 0. Table contents NOT reset (undefined until written).
- States: IDLE, RUN, FIN.
- IDLE: cfg_we writes table[cfg_addr] at edge. start=1 (sampled) -> RUN next cycle: cur_idx=0, stim_out=table[0].value, hold counter loaded, wd counter=0, busy=1, timeout cleared. Latency start->stim_out = 1 cycle.
- Hold: entry i drives stim_out for max(delay_i,1) cycles (delay 0 treated as 1).
- Advance: on last hold cycle of entry i: if i < cfg_len-1 -> i+1; else if loop_en -> 0; else -> FIN. New value visible exactly on next cycle, no bubble.
- FIN: one cycle; done=1, busy=0, stim_out holds last value; then IDLE. stim_out retains last value in IDLE until next start or reset.
- Watchdog: wd counter increments every RUN cycle; when wd == tmo_limit-1 and tmo_limit!=0 -> FIN, timeout=1 (sticky until next accepted start or reset). Watchdog has priority over normal advance in same cycle.
- stop in RUN -> FIN next cycle, timeout unchanged (0). stop priority over advance; watchdog priority over stop (timeout=1 if both).
- start in RUN or FIN ignored. cfg_we while busy=1 ignored (table frozen during playback).
- cfg_len=0 or >DEPTH treated as DEPTH. cfg_len, loop_en, tmo_limit sampled at start and held for the run.
- Counters saturate-free: hold counter DLY_W bits, wd counter TMO_W bits; no wrap possible given comparisons above.
- rst_n=0 mid-run: immediate return to reset values on that edge; no done pulse.

Optional Feature:
STIM_SEQ_TRACE_EN: when defined, adds outputs evt_pulse (1 bit, high for one cycle whenever stim_out changes value, including the start load) and evt_cnt (16 bits, number of evt_pulse since last accepted start, saturates at 0xFFFF, reset 0). When undefined, ports and logic absent; all other behaviour identical.

Decomposition:
- Package stim_seq_pkg: state enum (IDLE/RUN/FIN), entry struct {value, delay} parameterized via localparam widths, default constants.
- One sub-module natural: stim_seq_table (DEPTH x entry register file, sync write, async read by index).
- FSM, hold counter, watchdog in top.

Test Plan:
- Reset: drive rst_n=0 two cycles mid-run -> stim_out=0, busy=0, done never pulsed, timeout=0.
- Basic playback: NUM_CH=1, entries (0,25),(1,35),(0,40),(1,10), cfg_len=4, loop_en=0, tmo_limit=0, start at cycle T -> stim_out 0 for T+1..T+25, 1 for next 35, 0 for next 40, 1 for 10, done pulse at T+111, busy low from T+111.
- Zero delay/loop: entries (1,0),(2,3), NUM_CH=2, loop_en=1 -> pattern 1,2,2,2 repeating every 4 cycles; cur_idx toggles 0,1,1,1.
- Watchdog: loop_en=1, tmo_limit=1000 -> done and timeout=1 exactly 1000 cycles after first RUN cycle; stim_out frozen at value of that cycle.
- Stop vs watchdog collision: stop asserted on watchdog cycle -> timeout=1, single done pulse; stop alone -> timeout=0.
- Config lockout: cfg_we to entry 0 during busy -> next run shows original entry 0 value; start during RUN ignored (no restart, cur_idx continues).
